pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control-flow controller that drives program_counter: generates pc_enable, pc_sel and target_addr each cycle from the decoded control-flow op, the zero flag, stall and interrupt request.
- Owns the hardware return-address stack for CALL/RET and interrupt entry/exit.
- Detects stack faults and freezes fetch until reset.
- Sits between the decoder/ALU flags and program_counter; reads back the current pc.

Parameters:
DEPTH, 8, return-stack entries (power of two, 2..64)
IRQ_VECTOR, 19'h00010, interrupt service entry address

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  decoded op valid this cycle
op  in  3  000 SEQ, 001 BEQ, 010 BNE, 011 JMP, 100 CALL, 101 RET, 110 RETI, 111 treated as SEQ
zero_flag  in  1  ALU zero flag for BEQ/BNE
branch_addr  in  19  decoded target for BEQ/BNE/JMP/CALL
pc  in  19  current pc from program_counter
stall  in  1  pipeline stall; freezes everything
irq  in  1  level interrupt request
pc_enable  out  1  to program_counter
pc_sel  out  2  to program_counter
target_addr  out  20  to program_counter; bit 19 always 0
in_isr  out  1  interrupt service active
stack_overflow  out  1  sticky fault flag
stack_underflow  out  1  sticky fault flag

Behaviour:
- Reset (async, any state): state=IDLE, sp=0, irq_pending=0, in_isr=0, both fault flags=0. Outputs: pc_enable=0, pc_sel=00, target_addr=0.
- States:
  - IDLE: one cycle after reset release, outputs inactive, then RUN.
  - RUN: normal operation.
  - FAULT: pc_enable=0 forever; exit only via rst.
- pc_enable, pc_sel and target_addr are combinational from state and inputs, giving zero-cycle latency. program_counter updates on the same edge. Stack, sp, flags and state are registered.
- irq_pending is set on an irq rising edge, using a registered previous-irq sample. It is cleared when the interrupt is taken. If irq stays high, no retrigger occurs.
- RUN, stall=1: pc_enable=0; no stack, state or in_isr change. irq edges are still latched.
- RUN, stall=0, irq_pending=1 and in_isr=0: the interrupt takes priority and the current instruction is abandoned.
  - Push pc (not pc+1).
  - pc_sel=11, target_addr=IRQ_VECTOR, pc_enable=1.
  - Set in_isr, clear irq_pending.
  - If the stack is full: go to FAULT and set stack_overflow instead.
- RUN, stall=0, instr_valid=0: pc_enable=0.
- RUN, stall=0, instr_valid=1 (pc_enable=1 unless the op faults):
  - SEQ: pc_sel=00.
  - BEQ: pc_sel=01, target=branch_addr if zero_flag=1; else pc_sel=00.
  - BNE: same as BEQ with the flag condition inverted.
  - JMP: pc_sel=10, target=branch_addr.
  - CALL: push (pc+1) mod 2^19; pc_sel=10, target=branch_addr. Stack full -> overflow fault.
  - RET: pop; pc_sel=11, target=popped value. Stack empty -> underflow fault.
  - RETI: same as RET, and also clears in_isr. RETI with in_isr=0 behaves as RET.
- Fault cycle: pc_enable=0, no push/pop, sticky flag set, next state FAULT.
- Stack: sp counts 0..DEPTH. Full when sp==DEPTH, empty when sp==0. Push writes mem[sp] then sp+1; pop reads mem[sp-1] then sp-1. A pop value is visible combinationally the same cycle.
- Interrupts do not nest: while in_isr=1, irq edges latch but are not taken. A pending edge is taken on the first non-stalled RUN cycle after RETI.
- target_addr bit 19 is tied 0. Its value is don't-care when pc_sel=00, but the block drives 0.

Test Plan:
- Reset, then pc=0x00005, SEQ valid, no stall -> IDLE cycle with pc_enable=0, then pc_enable=1, pc_sel=00. Assert rst mid-CALL -> all outputs 0 and sp=0 immediately (async).
- BEQ with branch_addr=0x00100: zero_flag=1 -> pc_sel=01, target=0x00100. zero_flag=0 -> pc_sel=00. Repeat for BNE; results are inverted.
- CALL at pc=0x7FFFF to 0x00200, then RET -> first pc_sel=10/target 0x00200; RET gives pc_sel=11, target=0x00000 (wrap).
- DEPTH=8: nine nested CALLs -> ninth yields pc_enable=0, stack_overflow=1, FAULT. Later valid SEQ keeps pc_enable=0. RET on empty stack after reset -> stack_underflow=1.
- irq rising edge while a JMP is presented at pc=0x00040 -> pc_sel=11, target=0x00010, in_isr=1, pushed 0x00040. Second irq edge during ISR is not taken. RETI -> target 0x00040, in_isr=0. Pending irq is taken on the next non-stalled cycle.
- stall=1 held for 3 cycles with CALL valid -> pc_enable=0 and sp unchanged. Release -> single push, pc_sel=10.

Source files
------------

// File: rtl/pc_sequencer.sv
// Control-flow sequencer for program_counter: picks the next-pc source each cycle
// and owns the return-address stack used by CALL/RET and interrupt entry/exit.
module pc_sequencer #(
  parameter int          DEPTH      = 8,
  parameter logic [18:0] IRQ_VECTOR = 19'h00010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [2:0]  op,
  input  logic        zero_flag,
  input  logic [18:0] branch_addr,
  input  logic [18:0] pc,
  input  logic        stall,
  input  logic        irq,
  output logic        pc_enable,
  output logic [1:0]  pc_sel,
  output logic [19:0] target_addr,
  output logic        in_isr,
  output logic        stack_overflow,
  output logic        stack_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_RETI = 3'b110;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  logic [1:0]    state, state_next;
  logic [SW-1:0] sp;
  logic [18:0]   mem [DEPTH];
  logic          irq_prev, irq_pending, irq_rise;

  logic          stack_full, stack_empty;
  logic [AW-1:0] pop_idx;
  logic [18:0]   pop_data;
  logic [18:0]   tgt;
  logic [18:0]   push_data;
  logic          do_push, do_pop, take_irq, clr_isr, set_ovf, set_udf;

  assign stack_full  = (sp == SW'(DEPTH));
  assign stack_empty = (sp == '0);
  assign pop_idx     = AW'(sp - SW'(1));
  assign pop_data    = mem[pop_idx];
  assign irq_rise    = irq & ~irq_prev;
  assign target_addr = {1'b0, tgt};

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    pc_enable = 1'b0;
    pc_sel    = SEL_SEQ;
    tgt       = '0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    push_data = '0;
    take_irq  = 1'b0;
    clr_isr   = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;

    if (state == S_RUN && !stall) begin
      if (irq_pending && !in_isr) begin
        // Interrupt wins: the presented instruction is re-fetched after RETI.
        if (stack_full) begin
          set_ovf = 1'b1;
        end else begin
          take_irq  = 1'b1;
          do_push   = 1'b1;
          push_data = pc;
          pc_enable = 1'b1;
          pc_sel    = SEL_RET;
          tgt       = IRQ_VECTOR;
        end
      end else if (instr_valid) begin
        pc_enable = 1'b1;
        case (op)
          OP_BEQ: if (zero_flag) begin
            pc_sel = SEL_BR;
            tgt    = branch_addr;
          end
          OP_BNE: if (!zero_flag) begin
            pc_sel = SEL_BR;
            tgt    = branch_addr;
          end
          OP_JMP: begin
            pc_sel = SEL_JMP;
            tgt    = branch_addr;
          end
          OP_CALL: begin
            if (stack_full) begin
              set_ovf   = 1'b1;
              pc_enable = 1'b0;
            end else begin
              do_push   = 1'b1;
              push_data = pc + 19'd1;
              pc_sel    = SEL_JMP;
              tgt       = branch_addr;
            end
          end
          OP_RET, OP_RETI: begin
            if (stack_empty) begin
              set_udf   = 1'b1;
              pc_enable = 1'b0;
            end else begin
              do_pop  = 1'b1;
              pc_sel  = SEL_RET;
              tgt     = pop_data;
              clr_isr = (op == OP_RETI);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_RUN;
      S_RUN:   if (set_ovf || set_udf) state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      sp              <= '0;
      irq_prev        <= 1'b0;
      irq_pending     <= 1'b0;
      in_isr          <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      state    <= state_next;
      irq_prev <= irq;
      // A fresh edge arriving on the very cycle the interrupt is taken stays pending.
      irq_pending <= take_irq ? irq_rise : (irq_pending | irq_rise);
      if (do_push)     sp <= sp + SW'(1);
      else if (do_pop) sp <= sp - SW'(1);
      if (take_irq)     in_isr <= 1'b1;
      else if (clr_isr) in_isr <= 1'b0;
      if (set_ovf) stack_overflow  <= 1'b1;
      if (set_udf) stack_underflow <= 1'b1;
    end
  end

  // NOTE: stack storage has no reset; sp alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[sp[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam int          DEPTH = 8;
  localparam logic [18:0] IRQV  = 19'h00010;

  localparam int M_IDLE = 0, M_RUN = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        zero_flag = 1'b0;
  logic [18:0] branch_addr = '0;
  logic [18:0] pc = '0;
  logic        stall = 1'b0;
  logic        irq = 1'b0;
  logic        pc_enable;
  logic [1:0]  pc_sel;
  logic [19:0] target_addr;
  logic        in_isr, stack_overflow, stack_underflow;

  pc_sequencer #(.DEPTH(DEPTH), .IRQ_VECTOR(IRQV)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .zero_flag(zero_flag),
    .branch_addr(branch_addr), .pc(pc), .stall(stall), .irq(irq),
    .pc_enable(pc_enable), .pc_sel(pc_sel), .target_addr(target_addr),
    .in_isr(in_isr), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_state;
  logic [18:0] m_stack[$];
  bit          m_isr, m_pend, m_prev, m_ovf, m_udf;

  // Observations captured at the last step, for directed constant checks
  logic        o_en;
  logic [1:0]  o_sel;
  logic [19:0] o_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_stack.delete();
    m_isr = 0; m_pend = 0; m_prev = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_en",  pc_enable, 0);
    check("rst_sel", pc_sel, 0);
    check("rst_tgt", target_addr, 0);
    check("rst_isr", in_isr, 0);
    check("rst_ovf", stack_overflow, 0);
    check("rst_udf", stack_underflow, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic [2:0] o, input logic z,
                      input logic [18:0] ba, input logic [18:0] p,
                      input logic s, input logic ir);
    logic        e_en;
    logic [1:0]  e_sel;
    logic [18:0] e_tgt;
    bit take, push_call, pop, clr, f_ovf, f_udf, rise;
    logic [18:0] nxt;
    instr_valid = v; op = o; zero_flag = z; branch_addr = ba; pc = p; stall = s; irq = ir;
    #1;
    e_en = 0; e_sel = 0; e_tgt = 0;
    take = 0; push_call = 0; pop = 0; clr = 0; f_ovf = 0; f_udf = 0;
    nxt = p + 19'd1;
    if (m_state == M_RUN && !s) begin
      if (m_pend && !m_isr) begin
        if (m_stack.size() == DEPTH) f_ovf = 1;
        else begin take = 1; e_en = 1; e_sel = 2'b11; e_tgt = IRQV; end
      end else if (v) begin
        e_en = 1;
        case (o)
          3'd1: if (z)  begin e_sel = 2'b01; e_tgt = ba; end
          3'd2: if (!z) begin e_sel = 2'b01; e_tgt = ba; end
          3'd3: begin e_sel = 2'b10; e_tgt = ba; end
          3'd4: if (m_stack.size() == DEPTH) begin f_ovf = 1; e_en = 0; end
                else begin push_call = 1; e_sel = 2'b10; e_tgt = ba; end
          3'd5, 3'd6: if (m_stack.size() == 0) begin f_udf = 1; e_en = 0; end
                else begin pop = 1; e_sel = 2'b11; e_tgt = m_stack[$]; clr = (o == 3'd6); end
          default: ;
        endcase
      end
    end
    o_en = pc_enable; o_sel = pc_sel; o_tgt = target_addr;
    check("pc_enable",       pc_enable, e_en);
    check("pc_sel",          pc_sel, e_sel);
    check("target_addr",     target_addr, {1'b0, e_tgt});
    check("in_isr",          in_isr, m_isr);
    check("stack_overflow",  stack_overflow, m_ovf);
    check("stack_underflow", stack_underflow, m_udf);
    @(posedge clk);
    rise   = ir && !m_prev;
    m_prev = ir;
    m_pend = take ? rise : (m_pend | rise);
    if (take)      begin m_stack.push_back(p); m_isr = 1; end
    if (push_call) m_stack.push_back(nxt);
    if (pop)       begin void'(m_stack.pop_back()); if (clr) m_isr = 0; end
    if (f_ovf) m_ovf = 1;
    if (f_udf) m_udf = 1;
    if (m_state == M_IDLE) m_state = M_RUN;
    else if (f_ovf || f_udf) m_state = M_FAULT;
    #1;
  endtask

  initial begin
    model_reset();
    #2;
    check("init_en",  pc_enable, 0);
    check("init_sel", pc_sel, 0);
    check("init_tgt", target_addr, 0);
    check("init_isr", in_isr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IDLE cycle then first sequential fetch
    step(1, 3'd0, 0, 19'h0, 19'h00005, 0, 0);
    check("idle_en", o_en, 0);
    step(1, 3'd0, 0, 19'h0, 19'h00005, 0, 0);
    check("seq_en", o_en, 1);

    // Conditional branches
    step(1, 3'd1, 1, 19'h00100, 19'h6, 0, 0);
    check("beq_taken_sel", o_sel, 2'b01);
    check("beq_taken_tgt", o_tgt, 20'h00100);
    step(1, 3'd1, 0, 19'h00100, 19'h7, 0, 0);
    check("beq_nt_sel", o_sel, 2'b00);
    step(1, 3'd2, 1, 19'h00100, 19'h8, 0, 0);
    check("bne_nt_sel", o_sel, 2'b00);
    step(1, 3'd2, 0, 19'h00100, 19'h9, 0, 0);
    check("bne_taken_sel", o_sel, 2'b01);

    // CALL at top of address space, RET wraps to zero
    step(1, 3'd4, 0, 19'h00200, 19'h7FFFF, 0, 0);
    check("call_sel", o_sel, 2'b10);
    check("call_tgt", o_tgt, 20'h00200);
    step(1, 3'd5, 0, 19'h0, 19'h00200, 0, 0);
    check("ret_wrap_sel", o_sel, 2'b11);
    check("ret_wrap_tgt", o_tgt, 20'h00000);

    // Async reset asserted while a CALL is being presented
    instr_valid = 1; op = 3'd4; pc = 19'h00300; branch_addr = 19'h00400;
    #1;
    check("midcall_en", pc_enable, 1);
    do_reset();
    step(0, 3'd0, 0, 19'h0, 19'h0, 0, 0);

    // Nine nested CALLs overflow an eight-deep stack
    for (int i = 0; i < 9; i++) step(1, 3'd4, 0, 19'h00500 + 19'(i), 19'h01000 + 19'(i), 0, 0);
    check("ovf_en", o_en, 0);
    step(1, 3'd0, 0, 19'h0, 19'h2000, 0, 0);
    check("fault_en", o_en, 0);
    check("ovf_flag", stack_overflow, 1);

    // RET on an empty stack
    do_reset();
    step(0, 3'd0, 0, 19'h0, 19'h0, 0, 0);
    step(1, 3'd5, 0, 19'h0, 19'h00020, 0, 0);
    check("udf_en", o_en, 0);
    step(1, 3'd0, 0, 19'h0, 19'h00020, 0, 0);
    check("udf_flag", stack_underflow, 1);

    // Interrupt entry, non-nesting, RETI and deferred pending interrupt
    do_reset();
    step(0, 3'd0, 0, 19'h0, 19'h0, 0, 0);
    step(1, 3'd0, 0, 19'h0, 19'h0003F, 0, 1);
    step(1, 3'd3, 0, 19'h00123, 19'h00040, 0, 1);
    check("irq_sel", o_sel, 2'b11);
    check("irq_tgt", o_tgt, 20'h00010);
    step(1, 3'd0, 0, 19'h0, 19'h00010, 0, 0);
    check("isr_set", in_isr, 1);
    step(1, 3'd0, 0, 19'h0, 19'h00011, 0, 1);
    step(1, 3'd0, 0, 19'h0, 19'h00012, 0, 1);
    check("no_nest_sel", o_sel, 2'b00);
    step(1, 3'd6, 0, 19'h0, 19'h00013, 0, 1);
    check("reti_tgt", o_tgt, 20'h00040);
    step(1, 3'd0, 0, 19'h0, 19'h00040, 1, 1);
    check("isr_clr", in_isr, 0);
    step(1, 3'd0, 0, 19'h0, 19'h00040, 0, 1);
    check("pend_taken_tgt", o_tgt, 20'h00010);

    // Stalled CALL pushes exactly once
    do_reset();
    step(0, 3'd0, 0, 19'h0, 19'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3'd4, 0, 19'h00300, 19'h00050, 1, 0);
      check("stall_en", o_en, 0);
    end
    step(1, 3'd4, 0, 19'h00300, 19'h00050, 0, 0);
    check("stall_rel_sel", o_sel, 2'b10);
    step(1, 3'd5, 0, 19'h0, 19'h00300, 0, 0);
    check("stall_ret_tgt", o_tgt, 20'h00051);
    step(1, 3'd5, 0, 19'h0, 19'h00051, 0, 0);
    check("stall_single_push", o_en, 0);

    // Random traffic against the model
    do_reset();
    begin
      logic r_irq;
      r_irq = 1'b0;
      for (int i = 0; i < 800; i++) begin
        logic [2:0] r_op;
        if ((m_state == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
          do_reset();
        if ($urandom_range(0, 99) < 8) r_irq = ~r_irq;
        r_op = 3'($urandom_range(0, 7));
        step($urandom_range(0, 9) < 8, r_op, 1'($urandom_range(0, 1)),
             19'($urandom), 19'($urandom), $urandom_range(0, 99) < 15, r_irq);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
